// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// ALUOp codes (also used by the ALU control unit) and the control bundle.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       irwrite;
    logic       alusrca;
    logic       regwrite;
    logic       regdst;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctl_t;

endpackage

// File: rtl/mips_multicycle_control_decode.sv
// Pure state-to-control decoder (Moore outputs); unknown states decode to all-zero.
module mips_ctl_decode
  import mips_multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  output ctl_t               ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      STATE_W'(FETCH): begin
        ctl.memread  = 1'b1;
        ctl.irwrite  = 1'b1;
        ctl.alusrcb  = SRCB_FOUR;
        ctl.aluop    = ALU_ADD;
        ctl.pcsource = PC_ALU;
        ctl.pcwrite  = 1'b1;
      end
      STATE_W'(DECODE): begin
        ctl.alusrcb = SRCB_IMMSH2;
        ctl.aluop   = ALU_ADD;
      end
      STATE_W'(MEMADR), STATE_W'(ADDIEX): begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALU_ADD;
      end
      STATE_W'(MEMRD): begin
        ctl.memread = 1'b1;
        ctl.iord    = 1'b1;
      end
      STATE_W'(MEMWB): begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
      end
      STATE_W'(MEMWR): begin
        ctl.memwrite = 1'b1;
        ctl.iord     = 1'b1;
      end
      STATE_W'(EXEC): begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_REG;
        ctl.aluop   = ALU_FUNCT;
      end
      STATE_W'(RWB): begin
        ctl.regwrite = 1'b1;
        ctl.regdst   = 1'b1;
      end
      STATE_W'(BRANCH): begin
        ctl.alusrca     = 1'b1;
        ctl.alusrcb     = SRCB_REG;
        ctl.aluop       = ALU_SUB;
        ctl.pcwritecond = 1'b1;
        ctl.pcsource    = PC_ALUOUT;
      end
      STATE_W'(JUMP): begin
        ctl.pcwrite  = 1'b1;
        ctl.pcsource = PC_JUMP;
      end
      STATE_W'(ADDIWB): begin
        ctl.regwrite = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute;
// outputs are decoded from the state register only.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         Op,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctl_t               ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_W'(FETCH);
    else        state_q <= state_d;
  end

  // Op is consulted at DECODE and again at MEMADR to split lw from sw.
  always_comb begin
    state_d = STATE_W'(FETCH);
    case (state_q)
      STATE_W'(FETCH):  state_d = STATE_W'(DECODE);
      STATE_W'(DECODE): begin
        case (Op)
          OP_LW, OP_SW: state_d = STATE_W'(MEMADR);
          OP_RTYPE:     state_d = STATE_W'(EXEC);
          OP_BEQ:       state_d = STATE_W'(BRANCH);
          OP_J:         state_d = STATE_W'(JUMP);
          OP_ADDI:      state_d = STATE_W'(ADDIEX);
          default:      state_d = STATE_W'(FETCH);
        endcase
      end
      STATE_W'(MEMADR): begin
        if      (Op == OP_LW) state_d = STATE_W'(MEMRD);
        else if (Op == OP_SW) state_d = STATE_W'(MEMWR);
        else                  state_d = STATE_W'(FETCH);
      end
      STATE_W'(MEMRD):  state_d = STATE_W'(MEMWB);
      STATE_W'(EXEC):   state_d = STATE_W'(RWB);
      STATE_W'(ADDIEX): state_d = STATE_W'(ADDIWB);
      default:          state_d = STATE_W'(FETCH);
    endcase
  end

  mips_ctl_decode #(.STATE_W(STATE_W)) u_decode (
    .state (state_q),
    .ctl   (ctl)
  );

  assign PCWrite     = ctl.pcwrite;
  assign PCWriteCond = ctl.pcwritecond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.memread;
  assign MemWrite    = ctl.memwrite;
  assign MemtoReg    = ctl.memtoreg;
  assign IRWrite     = ctl.irwrite;
  assign ALUSrcA     = ctl.alusrca;
  assign RegWrite    = ctl.regwrite;
  assign RegDst      = ctl.regdst;
  assign PCSource    = ctl.pcsource;
  assign ALUSrcB     = ctl.alusrcb;
  assign ALUOp       = ctl.aluop;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-opcode state walks from a
// table plus hand-written reset and Op-resampling sequences.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst,PCSource,ALUSrcB,ALUOp}
  logic [15:0] outv;
  assign outv = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                 IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp};

  logic [15:0] exp_tbl [16];

  typedef struct {
    string      name;
    logic [5:0] op;
    int         n;
    logic [3:0] seq [6];
  } vec_t;

  vec_t vecs [$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_state(input string nm, input int st);
    chk($sformatf("%s_state", nm), 32'(state), 32'(st));
    chk($sformatf("%s_out", nm), 32'(outv), 32'(exp_tbl[st]));
    chk($sformatf("%s_aluop11", nm), 32'(ALUOp == 2'b11), 32'd0);
    chk($sformatf("%s_pcw_excl", nm), 32'(PCWrite & PCWriteCond), 32'd0);
    chk($sformatf("%s_mem_excl", nm), 32'(MemRead & MemWrite), 32'd0);
  endtask

  task automatic step_expect(input string nm, input int st);
    @(posedge clk);
    #1;
    chk_state(nm, st);
  endtask

  task automatic add_vec(input string nm, input logic [5:0] op, input int n,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [3:0] s3, input logic [3:0] s4, input logic [3:0] s5);
    vec_t v;
    v.name = nm; v.op = op; v.n = n;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2;
    v.seq[3] = s3; v.seq[4] = s4; v.seq[5] = s5;
    vecs.push_back(v);
  endtask

  // Reset asserted at a negedge, then released at the next negedge with Op applied.
  task automatic reset_release(input logic [5:0] op);
    @(negedge clk);
    rst_n = 1'b0;
    Op = op;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_tbl[i] = 16'h0;
    exp_tbl[0]  = 16'b1_0_0_1_0_0_1_0_0_0_00_01_00;
    exp_tbl[1]  = 16'b0_0_0_0_0_0_0_0_0_0_00_11_00;
    exp_tbl[2]  = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
    exp_tbl[3]  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    exp_tbl[4]  = 16'b0_0_0_0_0_1_0_0_1_0_00_00_00;
    exp_tbl[5]  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    exp_tbl[6]  = 16'b0_0_0_0_0_0_0_1_0_0_00_00_10;
    exp_tbl[7]  = 16'b0_0_0_0_0_0_0_0_1_1_00_00_00;
    exp_tbl[8]  = 16'b0_1_0_0_0_0_0_1_0_0_01_00_01;
    exp_tbl[9]  = 16'b1_0_0_0_0_0_0_0_0_0_10_00_00;
    exp_tbl[10] = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
    exp_tbl[11] = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

    add_vec("lw",    6'b100011, 6, 0, 1, 2, 3, 4, 0);
    add_vec("sw",    6'b101011, 5, 0, 1, 2, 5, 0, 0);
    add_vec("rtype", 6'b000000, 5, 0, 1, 6, 7, 0, 0);
    add_vec("beq",   6'b000100, 4, 0, 1, 8, 0, 0, 0);
    add_vec("j",     6'b000010, 4, 0, 1, 9, 0, 0, 0);
    add_vec("addi",  6'b001000, 5, 0, 1, 10, 11, 0, 0);
    add_vec("ill3f", 6'b111111, 3, 0, 1, 0, 0, 0, 0);
    add_vec("ill01", 6'b000001, 3, 0, 1, 0, 0, 0, 0);

    rst_n = 1'b0;
    Op = 6'b000000;
    #2;
    chk_state("por", 0);

    foreach (vecs[i]) begin
      reset_release(vecs[i].op);
      chk_state($sformatf("%s_c0", vecs[i].name), int'(vecs[i].seq[0]));
      for (int k = 1; k < vecs[i].n; k++)
        step_expect($sformatf("%s_c%0d", vecs[i].name, k), int'(vecs[i].seq[k]));
    end

    // Asynchronous reset in the middle of MEMRD, with no clock edge.
    reset_release(6'b100011);
    step_expect("arst_d", 1);
    step_expect("arst_a", 2);
    step_expect("arst_r", 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_memread", 32'(MemRead), 32'd1);
    chk("arst_irwrite", 32'(IRWrite), 32'd1);
    chk("arst_pcwrite", 32'(PCWrite), 32'd1);
    step_expect("arst_hold", 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_expect("arst_rel", 1);

    // Op changes mid-state must not disturb Moore outputs; MEMADR resamples Op.
    reset_release(6'b100011);
    step_expect("rs1_dec", 1);
    @(negedge clk);
    Op = 6'b101011;
    #1;
    chk_state("rs1_moore", 1);
    step_expect("rs1_adr", 2);
    @(negedge clk);
    Op = 6'b100011;
    step_expect("rs1_rd", 3);
    step_expect("rs1_wb", 4);
    step_expect("rs1_end", 0);

    reset_release(6'b101011);
    step_expect("rs2_dec", 1);
    step_expect("rs2_adr", 2);
    @(negedge clk);
    Op = 6'b000000;
    step_expect("rs2_fetch", 0);

    // Back-to-back jumps without intervening reset.
    reset_release(6'b000010);
    for (int r = 0; r < 2; r++) begin
      step_expect($sformatf("bb%0d_dec", r), 1);
      step_expect($sformatf("bb%0d_jmp", r), 9);
      step_expect($sformatf("bb%0d_fet", r), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
MIPS_MULTICYCLE_CONTROL -- requirements
Module: mips_multicycle_control

Interface
REQ-001 Parameter: STATE_W, default 4, width of state register and debug port.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for the state register.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 Op  input  6  opcode field from the instruction register (IR[31:26]).
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath control strobes/selects.
REQ-007 PCSource, ALUSrcB  output  2 each  PC mux select; ALU B mux select (00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2).
REQ-008 ALUOp  output  2  encoding consumed by the downstream ALU control unit: 00 add, 01 subtract, 10 decode funct.
REQ-009 state  output  STATE_W  current state, for debug/verification.

Function
REQ-010 Moore FSM; all outputs SHALL be a pure decode of the state register, with no combinational dependence on Op.
REQ-011 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-013 Transitions:
  - FETCH->DECODE
  - DECODE: lw/sw->MEMADR; R->EXEC; beq->BRANCH; j->JUMP; addi->ADDIEX; any other opcode->FETCH
  - MEMADR: lw->MEMRD; sw->MEMWR; other->FETCH (Op sampled again at this edge)
  - MEMRD->MEMWB
  - EXEC->RWB
  - ADDIEX->ADDIWB
  - MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB -> FETCH
REQ-014 Outputs asserted per state; every unlisted output SHALL be 0:
  - FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1
  - DECODE: ALUSrcB=11, ALUOp=00
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - MEMRD: MemRead=1, IorD=1
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0
  - MEMWR: MemWrite=1, IorD=1
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10
  - RWB: RegWrite=1, RegDst=1
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01
  - JUMP: PCWrite=1, PCSource=10
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00
  - ADDIWB: RegWrite=1, RegDst=0
REQ-015 Instruction latency in cycles, FETCH inclusive: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
REQ-016 ALUOp=11 SHALL never be driven.
REQ-017 PCWrite and PCWriteCond SHALL never both be 1; MemRead and MemWrite SHALL never both be 1.
REQ-018 State encodings 12..15 are unreachable; if entered, the FSM SHALL go to FETCH on the next edge and drive all outputs 0 while in that state.

Reset
REQ-019 rst_n low SHALL force state to FETCH immediately, with no clock edge required, and hold it there.
REQ-020 While in reset, outputs SHALL equal the FETCH decode; datapath registers are held by the same reset.
REQ-021 Reset asserted in any state SHALL abandon the instruction; the first rising edge after deassertion SHALL move FETCH->DECODE.

Structure
REQ-022 Shared package holds the state encodings, opcode constants, and ALUOp codes (ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10), shared with the ALU control unit.
REQ-023 One sub-module: mips_ctl_decode, the combinational state-to-output decoder; next-state logic and the state register stay in the top module.

Verification
REQ-024 Reset: rst_n=0 mid-MEMRD, no clock edge -> state=0, MemRead=1, IRWrite=1, PCWrite=1 immediately.
REQ-025 lw: Op=100011 from reset release -> states 0,1,2,3,4,0; MemWB cycle shows RegWrite=1, MemtoReg=1.
REQ-026 R-type/beq: Op=000000 -> 0,1,6,7,0 with ALUOp=10 in state 6; Op=000100 -> 0,1,8,0 with ALUOp=01 and PCWriteCond=1 in state 8.
REQ-027 sw/j/addi: Op=101011 -> 0,1,2,5,0 (MemWrite=1 only in 5); Op=000010 -> 0,1,9,0 (PCSource=10); Op=001000 -> 0,1,10,11,0.
REQ-028 Illegal opcode: Op=111111 -> 0,1,0; no RegWrite, MemWrite, or PCWriteCond asserted throughout.
REQ-029 Assertions checked on every cycle: ALUOp!=11; REQ-017 exclusions hold.
